// File: rtl/gray_pkg.sv
// Shared types and helpers for the gray-sequence checker: FSM encoding and gray decode.
// Pure definitions, no state; no flow control.
package gray_pkg;

    localparam int GRAY_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// Combinational gray-to-binary decoder, WIDTH bits.
// Zero latency; no flow control.
module gray2bin_dec
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    if (WIDTH == GRAY_W) begin : g_pkg
        assign bin_o = gray2bin(gray_i);
    end else begin : g_loop
        always_comb begin
            bin_o[WIDTH-1] = gray_i[WIDTH-1];
            for (int i = WIDTH - 2; i >= 0; i--) begin
                bin_o[i] = bin_o[i+1] ^ gray_i[i];
            end
        end
    end

endmodule

// File: rtl/verificador_gray_sync.sv
// Checks that a registered gray stream advances by +1 per enabled cycle; lock FSM + error counter.
// One cycle from gray_in sample to bin_out/flags; enable=0 drops to IDLE, no backpressure.
module verificador_gray_sync
    import gray_pkg::*;
#(
    parameter int WIDTH    = GRAY_W,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             locked,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int                CNT_W    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  LOCK_VAL = CNT_W'(LOCK_CNT);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_out_q, bin_out_d;
    logic [WIDTH-1:0]   prev_bin_q, prev_bin_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic               bin_valid_q, bin_valid_d;
    logic               locked_q, locked_d;
    logic               seq_err_q, seq_err_d;

    logic [WIDTH-1:0]   dec_bin;
    logic [CNT_W-1:0]   cnt_inc;
    logic               match;

    gray2bin_dec #(.WIDTH(WIDTH)) u_dec (
        .gray_i (gray_in),
        .bin_o  (dec_bin)
    );

    // Natural WIDTH-bit wrap makes the all-ones -> zero step a valid increment.
    assign match   = (dec_bin == prev_bin_q + WIDTH'(1));
    assign cnt_inc = match_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        bin_out_d   = bin_out_q;
        bin_valid_d = bin_valid_q;
        locked_d    = locked_q;
        seq_err_d   = 1'b0;
        err_count_d = err_count_q;
        prev_bin_d  = prev_bin_q;
        match_cnt_d = match_cnt_q;

        if (!enable) begin
            state_d     = ST_IDLE;
            bin_valid_d = 1'b0;
            locked_d    = 1'b0;
            match_cnt_d = '0;
        end else begin
            bin_out_d   = dec_bin;
            bin_valid_d = 1'b1;
            prev_bin_d  = dec_bin;
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_ACQUIRE;
                    match_cnt_d = '0;
                    locked_d    = 1'b0;
                end
                ST_ACQUIRE: begin
                    if (match) begin
                        match_cnt_d = cnt_inc;
                        if (cnt_inc == LOCK_VAL) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!match) begin
                        state_d   = ST_ERROR;
                        seq_err_d = 1'b1;
                        locked_d  = 1'b0;
                        if (err_count_q != ERR_MAX) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                    end
                end
                ST_ERROR: begin
                    // The sample seen here only resynchronises prev_bin.
                    match_cnt_d = '0;
                    state_d     = ST_ACQUIRE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (clr_err) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bin_out_q   <= '0;
            bin_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            seq_err_q   <= 1'b0;
            err_count_q <= '0;
            prev_bin_q  <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bin_out_q   <= bin_out_d;
            bin_valid_q <= bin_valid_d;
            locked_q    <= locked_d;
            seq_err_q   <= seq_err_d;
            err_count_q <= err_count_d;
            prev_bin_q  <= prev_bin_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign bin_out   = bin_out_q;
    assign bin_valid = bin_valid_q;
    assign locked    = locked_q;
    assign seq_err   = seq_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_verificador_gray_sync.sv
// Directed bench for verificador_gray_sync: expectations queued at drive time, checked one edge later.
module tb_verificador_gray_sync;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       clr_err;
    logic [4:0] gray_in;
    logic [4:0] bin_out;
    logic       bin_valid;
    logic       locked;
    logic       seq_err;
    logic [7:0] err_count;

    typedef struct {
        logic [4:0] b;
        logic       v;
        logic       l;
        logic       s;
        logic [7:0] e;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         fails   = 0;
    int         errc    = 0;
    logic [4:0] lb      = 5'd0;
    logic [4:0] c;

    always #5 clk = ~clk;

    verificador_gray_sync #(.WIDTH(5), .LOCK_CNT(4), .ERR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clr_err   (clr_err),
        .gray_in   (gray_in),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .locked    (locked),
        .seq_err   (seq_err),
        .err_count (err_count)
    );

    task automatic step(input logic r, input logic en, input logic clr, input logic [4:0] bv,
                        input logic [4:0] eb, input logic ev, input logic el, input logic es,
                        input logic [7:0] ee);
        exp_t x;
        reset   = r;
        enable  = en;
        clr_err = clr;
        gray_in = bv ^ (bv >> 1);
        x.b = eb; x.v = ev; x.l = el; x.s = es; x.e = ee;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        vectors++;
        assert (bin_out === x.b) else begin
            fails++;
            $error("FAIL bin_out t=%0t got %0d want %0d", $time, bin_out, x.b);
        end
        vectors++;
        assert (bin_valid === x.v) else begin
            fails++;
            $error("FAIL bin_valid t=%0t got %0b want %0b", $time, bin_valid, x.v);
        end
        vectors++;
        assert (locked === x.l) else begin
            fails++;
            $error("FAIL locked t=%0t got %0b want %0b", $time, locked, x.l);
        end
        vectors++;
        assert (seq_err === x.s) else begin
            fails++;
            $error("FAIL seq_err t=%0t got %0b want %0b", $time, seq_err, x.s);
        end
        vectors++;
        assert (err_count === x.e) else begin
            fails++;
            $error("FAIL err_count t=%0t got %0d want %0d", $time, err_count, x.e);
        end
    endtask

    // Enabled sample of binary value b; a break bumps the saturating error count.
    task automatic s1(input logic [4:0] b, input logic el, input logic es);
        if (es && errc < 255) errc++;
        lb = b;
        step(1'b0, 1'b1, 1'b0, b, b, 1'b1, el, es, errc[7:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; clr_err = 1'b0; gray_in = 5'd0;

        // Reset state, and reset overriding enable/clr_err
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Acquire on 1..5
        s1(5'd1, 1'b0, 1'b0);
        s1(5'd2, 1'b0, 1'b0);
        s1(5'd3, 1'b0, 1'b0);
        s1(5'd4, 1'b0, 1'b0);
        s1(5'd5, 1'b1, 1'b0);

        // Run through the 31 -> 0 wrap while locked
        for (int i = 6; i <= 31; i++) s1(5'(i), 1'b1, 1'b0);
        s1(5'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) s1(5'(i), 1'b1, 1'b0);

        // Skip 5 -> 8, then relock
        s1(5'd8,  1'b0, 1'b1);
        s1(5'd9,  1'b0, 1'b0);
        s1(5'd10, 1'b0, 1'b0);
        s1(5'd11, 1'b0, 1'b0);
        s1(5'd12, 1'b0, 1'b0);
        s1(5'd13, 1'b1, 1'b0);
        c = 5'd13;

        // Drive err_count to saturation
        while (errc < 255) begin
            c = c + 5'd3; s1(c, 1'b0, 1'b1);
            c = c + 5'd1; s1(c, 1'b0, 1'b0);
            repeat (3) begin c = c + 5'd1; s1(c, 1'b0, 1'b0); end
            c = c + 5'd1; s1(c, 1'b1, 1'b0);
        end
        c = c + 5'd3; s1(c, 1'b0, 1'b1);
        repeat (4) begin c = c + 5'd1; s1(c, 1'b0, 1'b0); end
        c = c + 5'd1; s1(c, 1'b1, 1'b0);

        // Break with clr_err on the same edge: clear wins
        c = c + 5'd3; errc = 0; lb = c;
        step(1'b0, 1'b1, 1'b1, c, c, 1'b1, 1'b0, 1'b1, 8'd0);
        repeat (4) begin c = c + 5'd1; s1(c, 1'b0, 1'b0); end
        c = c + 5'd1; s1(c, 1'b1, 1'b0);

        // Enable low for 3 cycles while locked; bin_out holds
        repeat (3) step(1'b0, 1'b0, 1'b0, 5'd9, lb, 1'b0, 1'b0, 1'b0, errc[7:0]);
        s1(5'd20, 1'b0, 1'b0);
        s1(5'd22, 1'b0, 1'b0);
        s1(5'd23, 1'b0, 1'b0);
        s1(5'd24, 1'b0, 1'b0);
        s1(5'd25, 1'b0, 1'b0);
        s1(5'd26, 1'b1, 1'b0);

        // Enable dropped the cycle after a break
        s1(5'd29, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 5'd30, lb, 1'b0, 1'b0, 1'b0, errc[7:0]);
        s1(5'd7,  1'b0, 1'b0);
        s1(5'd8,  1'b0, 1'b0);
        s1(5'd9,  1'b0, 1'b0);
        s1(5'd10, 1'b0, 1'b0);
        s1(5'd11, 1'b1, 1'b0);

        // One-cycle reset while locked
        step(1'b1, 1'b1, 1'b0, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        errc = 0;
        s1(5'd3, 1'b0, 1'b0);
        s1(5'd4, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
